// File: rtl/sdram_cmd_ctrl.sv
// SDRAM command/timing controller: power-up init, periodic auto-refresh,
// and single-word read/write sequencing for a 16-bit SDRAM. The work_state
// output tells the downstream data path which phase the controller is in.
`timescale 1ns/1ps

module sdram_cmd_ctrl #(
    parameter int          INIT_WAIT    = 20000,
    parameter int          REF_PERIOD   = 781,
    parameter int          INIT_REF_CNT = 8,
    parameter int          T_RP         = 2,
    parameter int          T_RFC        = 7,
    parameter int          T_MRD        = 2,
    parameter int          T_RCD        = 2,
    parameter int          T_WR         = 2,
    parameter int          CAS_LAT      = 3,
    parameter logic [12:0] MODE_REG     = 13'h030
) (
    input  logic        clk_100m,
    input  logic        rst_n,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [23:0] sys_addr,
    output logic        init_done,
    output logic        busy,
    output logic        rw_ack,
    output logic        rd_valid,
    output logic [3:0]  work_state,
    output logic        sdram_cke,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr
);

    // The init wait is the longest interval, so it sizes the shared counter.
    localparam int CNT_W = $clog2(INIT_WAIT + 1);
    localparam int REF_W = $clog2(REF_PERIOD);
    localparam int RN_W  = $clog2(INIT_REF_CNT + 1);

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_REF  = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;

    typedef enum logic [2:0] {
        I_WAIT, I_PRE, I_REF, I_MRS, I_DONE
    } init_t;

    typedef enum logic [3:0] {
        W_IDLE   = 4'd0,
        W_ACTIVE = 4'd1,
        W_TRCD   = 4'd2,
        W_READ   = 4'd3,
        W_CL     = 4'd4,
        W_RD     = 4'd5,
        W_WD     = 4'd7,
        W_TWR    = 4'd8,
        W_PRE    = 4'd9,
        W_TRP    = 4'd10,
        W_AR     = 4'd11,
        W_TRFC   = 4'd12
    } work_t;

    init_t             init_state;
    work_t             state;
    logic [CNT_W-1:0]  cnt;
    logic [RN_W-1:0]   ref_num;
    logic [REF_W-1:0]  ref_cnt;
    logic              ref_pending;
    logic              ref_take;
    logic              is_read;
    logic [1:0]        bank_q;
    logic [8:0]        col_q;
    logic [3:0]        cmd_q;

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
    assign work_state = state;
    assign busy       = !init_done || (state != W_IDLE);
    assign ref_take   = init_done && (state == W_IDLE) && ref_pending;
    // Acknowledge in the idle cycle itself so the address is latched on the
    // same edge that moves the FSM into W_ACTIVE; refresh always wins.
    assign rw_ack     = init_done && (state == W_IDLE) && !ref_pending
                        && (rd_req || wr_req);

    // Refresh interval timer; a wrap raises ref_pending until W_AR is entered.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
        end else if (init_done) begin
            if (ref_cnt == REF_W'(REF_PERIOD - 1)) begin
                ref_cnt     <= '0;
                ref_pending <= 1'b1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
                if (ref_take) begin
                    ref_pending <= 1'b0;
                end
            end
        end
    end

    // Init sequencer followed by the work FSM; every command lasts one cycle.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            init_state <= I_WAIT;
            state      <= W_IDLE;
            cnt        <= '0;
            ref_num    <= '0;
            init_done  <= 1'b0;
            rd_valid   <= 1'b0;
            is_read    <= 1'b0;
            bank_q     <= '0;
            col_q      <= '0;
            cmd_q      <= CMD_NOP;
            sdram_cke  <= 1'b0;
            sdram_ba   <= '0;
            sdram_addr <= '0;
        end else begin
            sdram_cke  <= 1'b1;
            cmd_q      <= CMD_NOP;
            sdram_ba   <= '0;
            sdram_addr <= '0;
            rd_valid   <= 1'b0;
            case (init_state)
                I_WAIT: begin
                    if (cnt == CNT_W'(INIT_WAIT)) begin
                        cmd_q      <= CMD_PRE;
                        sdram_addr <= 13'h0400;
                        cnt        <= '0;
                        init_state <= I_PRE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                I_PRE: begin
                    if (cnt == CNT_W'(T_RP)) begin
                        cmd_q      <= CMD_REF;
                        cnt        <= '0;
                        ref_num    <= RN_W'(1);
                        init_state <= I_REF;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                I_REF: begin
                    if (cnt == CNT_W'(T_RFC)) begin
                        cnt <= '0;
                        if (ref_num == RN_W'(INIT_REF_CNT)) begin
                            cmd_q      <= CMD_LMR;
                            sdram_addr <= MODE_REG;
                            init_state <= I_MRS;
                        end else begin
                            cmd_q   <= CMD_REF;
                            ref_num <= ref_num + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                I_MRS: begin
                    if (cnt == CNT_W'(T_MRD - 1)) begin
                        cnt        <= '0;
                        init_done  <= 1'b1;
                        init_state <= I_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                I_DONE: begin
                    case (state)
                        W_IDLE: begin
                            cnt <= '0;
                            if (ref_pending) begin
                                cmd_q <= CMD_REF;
                                state <= W_AR;
                            end else if (rd_req || wr_req) begin
                                cmd_q      <= CMD_ACT;
                                sdram_ba   <= sys_addr[23:22];
                                sdram_addr <= sys_addr[21:9];
                                bank_q     <= sys_addr[23:22];
                                col_q      <= sys_addr[8:0];
                                is_read    <= rd_req;
                                state      <= W_ACTIVE;
                            end
                        end
                        W_ACTIVE: begin
                            cnt   <= '0;
                            state <= W_TRCD;
                        end
                        W_TRCD: begin
                            if (cnt == CNT_W'(T_RCD - 2)) begin
                                cnt        <= '0;
                                cmd_q      <= is_read ? CMD_RD : CMD_WR;
                                sdram_ba   <= bank_q;
                                sdram_addr <= {4'b0000, col_q};
                                state      <= is_read ? W_READ : W_WD;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        W_READ: begin
                            cnt   <= '0;
                            state <= W_CL;
                        end
                        W_CL: begin
                            if (cnt == CNT_W'(CAS_LAT - 2)) begin
                                cnt      <= '0;
                                rd_valid <= 1'b1;
                                state    <= W_RD;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        W_RD: begin
                            cmd_q      <= CMD_PRE;
                            sdram_ba   <= bank_q;
                            sdram_addr <= 13'h0400;
                            state      <= W_PRE;
                        end
                        W_WD: begin
                            cnt   <= '0;
                            state <= W_TWR;
                        end
                        W_TWR: begin
                            if (cnt == CNT_W'(T_WR - 1)) begin
                                cnt        <= '0;
                                cmd_q      <= CMD_PRE;
                                sdram_ba   <= bank_q;
                                sdram_addr <= 13'h0400;
                                state      <= W_PRE;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        W_PRE: begin
                            cnt   <= '0;
                            state <= W_TRP;
                        end
                        W_TRP: begin
                            if (cnt == CNT_W'(T_RP - 2)) begin
                                cnt   <= '0;
                                state <= W_IDLE;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        W_AR: begin
                            cnt   <= '0;
                            state <= W_TRFC;
                        end
                        W_TRFC: begin
                            if (cnt == CNT_W'(T_RFC - 1)) begin
                                cnt   <= '0;
                                state <= W_IDLE;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        default: begin
                            cnt   <= '0;
                            state <= W_IDLE;
                        end
                    endcase
                end
                default: begin
                    cnt        <= '0;
                    init_state <= I_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_cmd_ctrl.sv
// Directed bench for sdram_cmd_ctrl: init sequence, read, write, read/write
// collision, refresh deferred by an access, and asynchronous mid-write reset.
`timescale 1ns/1ps

module tb_sdram_cmd_ctrl;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;

    // 24'h5AB3C1 -> bank 1, row 13'h0D59, col 9'h1C1
    localparam logic [23:0] ADDR_A = 24'h5AB3C1;
    // 24'hA55F3E -> bank 2, row 13'h12AF, col 9'h13E
    localparam logic [23:0] ADDR_B = 24'hA55F3E;

    logic        clk_100m = 1'b0;
    logic        rst_n    = 1'b0;
    logic        rd_req   = 1'b0;
    logic        wr_req   = 1'b0;
    logic [23:0] sys_addr = '0;
    logic        init_done, busy, rw_ack, rd_valid, sdram_cke;
    logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [3:0]  work_state;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic [3:0]  cmd;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    assign cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};

    sdram_cmd_ctrl dut (
        .clk_100m    (clk_100m),
        .rst_n       (rst_n),
        .rd_req      (rd_req),
        .wr_req      (wr_req),
        .sys_addr    (sys_addr),
        .init_done   (init_done),
        .busy        (busy),
        .rw_ack      (rw_ack),
        .rd_valid    (rd_valid),
        .work_state  (work_state),
        .sdram_cke   (sdram_cke),
        .sdram_cs_n  (sdram_cs_n),
        .sdram_ras_n (sdram_ras_n),
        .sdram_cas_n (sdram_cas_n),
        .sdram_we_n  (sdram_we_n),
        .sdram_ba    (sdram_ba),
        .sdram_addr  (sdram_addr)
    );

    // 100 MHz clock
    always #5 clk_100m = ~clk_100m;

    // Cycle index, advanced on every active edge
    always @(posedge clk_100m) cyc <= cyc + 1;

    // Watchdog against a stuck run
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic stepCycle;
        @(negedge clk_100m);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [23:0] addr);
        rd_req   = rd;
        wr_req   = wr;
        sys_addr = addr;
        #1;
    endtask

    task automatic stepTo(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 2000) begin
            stepCycle;
            guard++;
        end
    endtask

    // Advance to the next non-NOP command, bounded by limit cycles
    task automatic waitCmd(input string tag, input int limit, output int at);
        int n;
        n  = 0;
        at = -1;
        stepCycle;
        while (cmd === CMD_NOP && n < limit) begin
            stepCycle;
            n++;
        end
        checkOutput({tag, "_found"}, 32'(cmd !== CMD_NOP), 1);
        at = cyc;
    endtask

    task automatic checkReset(input string pfx);
        checkOutput({pfx, "_cke"},        sdram_cke,  0);
        checkOutput({pfx, "_cmd"},        cmd,        CMD_NOP);
        checkOutput({pfx, "_ba"},         sdram_ba,   0);
        checkOutput({pfx, "_addr"},       sdram_addr, 0);
        checkOutput({pfx, "_work_state"}, work_state, 0);
        checkOutput({pfx, "_init_done"},  init_done,  0);
        checkOutput({pfx, "_busy"},       busy,       1);
        checkOutput({pfx, "_rw_ack"},     rw_ack,     0);
        checkOutput({pfx, "_rd_valid"},   rd_valid,   0);
    endtask

    initial begin
        int c0, t, prev, lmr, done_cyc, k, rd_t, wr_t, f;

        $display("[TB] sdram_cmd_ctrl bench starting");

        // Reset state
        applyStimulus(0, 0, '0);
        repeat (3) stepCycle;
        checkReset("rst");

        // Release: cke rises on the first edge, requests are ignored during init
        rst_n = 1'b1;
        stepCycle;
        checkOutput("init_cke", sdram_cke, 1);
        c0 = cyc;
        applyStimulus(1, 0, ADDR_A);
        checkOutput("init_ack_blocked", rw_ack, 0);
        checkOutput("init_busy", busy, 1);
        applyStimulus(0, 0, '0);

        waitCmd("init_pre", 20100, t);
        checkOutput("init_pre_cmd",   cmd, CMD_PRE);
        checkOutput("init_pre_cycle", t - c0, 20000);
        checkOutput("init_pre_a10",   sdram_addr[10], 1);
        checkOutput("init_pre_ws",    work_state, 0);
        prev = t;

        for (int i = 0; i < 8; i++) begin
            waitCmd($sformatf("init_ref%0d", i), 20, t);
            checkOutput($sformatf("init_ref%0d_cmd", i), cmd, CMD_REF);
            checkOutput($sformatf("init_ref%0d_gap", i), t - prev, (i == 0) ? 3 : 8);
            prev = t;
        end

        waitCmd("init_lmr", 20, t);
        checkOutput("init_lmr_cmd",  cmd, CMD_LMR);
        checkOutput("init_lmr_gap",  t - prev, 8);
        checkOutput("init_lmr_addr", sdram_addr, 13'h030);
        checkOutput("init_lmr_ba",   sdram_ba, 0);
        lmr = t;
        stepCycle;
        checkOutput("init_done_early", init_done, 0);
        stepCycle;
        checkOutput("init_done_set", init_done, 1);
        checkOutput("init_busy_low", busy, 0);
        checkOutput("init_ws_idle",  work_state, 0);
        done_cyc = cyc;

        // Single read
        applyStimulus(1, 0, ADDR_A);
        checkOutput("rd_ack", rw_ack, 1);
        k = cyc;
        stepCycle;
        applyStimulus(0, 0, ADDR_A);
        checkOutput("rd_ack_pulse", rw_ack, 0);
        checkOutput("rd_act_cmd",   cmd, CMD_ACT);
        checkOutput("rd_act_ba",    sdram_ba, 1);
        checkOutput("rd_act_row",   sdram_addr, 13'h0D59);
        checkOutput("rd_act_ws",    work_state, 1);
        waitCmd("rd_read", 10, t);
        checkOutput("rd_read_cmd",  cmd, CMD_RD);
        checkOutput("rd_read_time", t - k, 3);
        checkOutput("rd_read_col",  sdram_addr, 13'h01C1);
        checkOutput("rd_read_ba",   sdram_ba, 1);
        checkOutput("rd_read_ws",   work_state, 3);
        rd_t = t;
        stepCycle;
        stepCycle;
        checkOutput("rd_valid_early", rd_valid, 0);
        stepCycle;
        checkOutput("rd_valid_set", rd_valid, 1);
        checkOutput("rd_ws_rd",     work_state, 5);
        waitCmd("rd_pre", 10, t);
        checkOutput("rd_pre_cmd",  cmd, CMD_PRE);
        checkOutput("rd_pre_time", t - rd_t, 4);
        checkOutput("rd_pre_a10",  sdram_addr[10], 1);
        stepCycle;
        checkOutput("rd_trp_busy", busy, 1);
        stepCycle;
        checkOutput("rd_idle_busy", busy, 0);

        // Single write
        applyStimulus(0, 1, ADDR_A);
        checkOutput("wr_ack", rw_ack, 1);
        k = cyc;
        stepCycle;
        applyStimulus(0, 0, ADDR_A);
        checkOutput("wr_act_cmd", cmd, CMD_ACT);
        waitCmd("wr_write", 10, t);
        checkOutput("wr_write_cmd",  cmd, CMD_WR);
        checkOutput("wr_write_time", t - k, 3);
        checkOutput("wr_write_ws",   work_state, 7);
        checkOutput("wr_write_col",  sdram_addr, 13'h01C1);
        wr_t = t;
        waitCmd("wr_pre", 10, t);
        checkOutput("wr_pre_cmd",  cmd, CMD_PRE);
        checkOutput("wr_pre_time", t - wr_t, 3);
        stepCycle;
        checkOutput("wr_trp_busy", busy, 1);
        stepCycle;
        checkOutput("wr_idle_busy", busy, 0);

        // Read and write together: read first, write acked at the next idle
        applyStimulus(1, 1, ADDR_A);
        checkOutput("both_ack_rd", rw_ack, 1);
        k = cyc;
        stepCycle;
        applyStimulus(0, 1, ADDR_A);
        checkOutput("both_act_cmd", cmd, CMD_ACT);
        waitCmd("both_first", 10, t);
        checkOutput("both_first_is_read", cmd, CMD_RD);
        stepTo(k + 8);
        checkOutput("both_wr_wait", rw_ack, 0);
        stepCycle;
        checkOutput("both_wr_ack",  rw_ack, 1);
        checkOutput("both_wr_idle", work_state, 0);
        stepCycle;
        applyStimulus(0, 0, ADDR_A);
        checkOutput("both_wr_act", cmd, CMD_ACT);
        waitCmd("both_second", 10, t);
        checkOutput("both_second_is_write", cmd, CMD_WR);
        waitCmd("both_pre", 10, t);
        checkOutput("both_pre_cmd", cmd, CMD_PRE);
        stepCycle;
        stepCycle;

        // Refresh wrap lands during a read; refresh precedes the held write
        stepTo(done_cyc + 776);
        applyStimulus(1, 1, ADDR_A);
        checkOutput("ref_rd_ack", rw_ack, 1);
        k = cyc;
        stepCycle;
        applyStimulus(0, 1, ADDR_B);
        waitCmd("ref_read", 10, t);
        checkOutput("ref_read_cmd", cmd, CMD_RD);
        stepTo(k + 9);
        checkOutput("ref_idle_noack", rw_ack, 0);
        checkOutput("ref_idle_ws",    work_state, 0);
        stepCycle;
        checkOutput("ref_ar_cmd",   cmd, CMD_REF);
        checkOutput("ref_ar_ws",    work_state, 11);
        checkOutput("ref_ar_noack", rw_ack, 0);
        f = cyc;
        stepTo(f + 7);
        checkOutput("ref_trfc_ws",    work_state, 12);
        checkOutput("ref_trfc_noack", rw_ack, 0);
        stepCycle;
        checkOutput("ref_wr_ack", rw_ack, 1);
        stepCycle;
        applyStimulus(0, 0, ADDR_B);
        checkOutput("ref_wr_act_cmd", cmd, CMD_ACT);
        checkOutput("ref_wr_act_ba",  sdram_ba, 2);
        checkOutput("ref_wr_act_row", sdram_addr, 13'h12AF);
        waitCmd("ref_write", 10, t);
        checkOutput("ref_write_cmd", cmd, CMD_WR);
        checkOutput("ref_write_col", sdram_addr, 13'h013E);
        checkOutput("ref_write_ba",  sdram_ba, 2);

        // Asynchronous reset in the middle of the write
        rst_n = 1'b0;
        #1;
        checkReset("midrst");
        repeat (2) stepCycle;
        rst_n = 1'b1;
        stepCycle;
        checkOutput("reinit_cke",  sdram_cke, 1);
        checkOutput("reinit_done", init_done, 0);
        c0 = cyc;
        waitCmd("reinit_pre", 20100, t);
        checkOutput("reinit_pre_cmd",   cmd, CMD_PRE);
        checkOutput("reinit_pre_cycle", t - c0, 20000);
        checkOutput("reinit_pre_ws",    work_state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
